phase_seq: RTL and testbench

Parametrised successor to the multi-cycle core's cycle controller. It sequences each RV32I instruction through phases P0 (PC/operand), P1 (address/rs2), P2 (execute/writeback) and P3 (branch redirect) on a digit-serial datapath, where every phase lasts XLEN/DIGIT_W beats. It adds four things over the cycle controller: an internal beat counter, a memory ready handshake, a global stall, and a trap hold state with acknowledge. It sits between the decoder (opcode, next_opcode) and the datapath/memory port.

---
 rtl/phase_seq_if.sv | 39 +++
 rtl/phase_seq.sv | 201 ++++++++++++++++++++
 tb/tb_phase_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_seq_if.sv
// Signal bundle between the phase sequencer (master) and the decoder/datapath/memory side (slave).
interface phase_seq_if #(
    parameter int XLEN    = 32,
    parameter int DIGIT_W = 8
);
    localparam int BEATS = XLEN / DIGIT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [4:0]    opcode;
    logic [4:0]    next_opcode;
    logic          branch_taken;
    logic          fwd_taken;
    logic          stall;
    logic          mem_ready;
    logic          trap_ack;
    logic [1:0]    phase;
    logic [BW-1:0] beat;
    logic          first_beat;
    logic          last_beat;
    logic          start;
    logic          rf_wren;
    logic          mem_rden;
    logic          mem_wren;
    logic          trap;
    logic          retire;
    logic [31:0]   instret;

    modport master (
        input  opcode, next_opcode, branch_taken, fwd_taken, stall, mem_ready, trap_ack,
        output phase, beat, first_beat, last_beat, start, rf_wren, mem_rden, mem_wren,
               trap, retire, instret
    );

    modport slave (
        output opcode, next_opcode, branch_taken, fwd_taken, stall, mem_ready, trap_ack,
        input  phase, beat, first_beat, last_beat, start, rf_wren, mem_rden, mem_wren,
               trap, retire, instret
    );
endinterface

// File: rtl/phase_seq.sv
// Phase sequencer for the digit-serial RV32I core: P0..P3, XLEN/DIGIT_W beats per phase.
// Define PHASE_SEQ_INSTRET_EN to build the 32-bit retired-instruction counter.
module phase_seq #(
    parameter int XLEN    = 32,
    parameter int DIGIT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    phase_seq_if.master bus
);
    localparam int BEATS = XLEN / DIGIT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;
    localparam logic [4:0] OPC_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;

    logic [1:0]    st_q, st_d;
    logic [1:0]    phase_q, phase_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          start_q, start_d;
    logic          wdone_q, wdone_d;

    logic       last, go;
    logic       rd_req, wr_req, rf_hit, ret, to_trap;
    logic [1:0] nxt_phase;
    logic [4:0] opc;

    function automatic logic needs_p1(input logic [4:0] o);
        return (o == OPC_OP) || (o == OPC_LOAD) || (o == OPC_STORE) ||
               (o == OPC_BRANCH) || (o == OPC_JALR);
    endfunction

    function automatic logic [1:0] fwd_phase(input logic [4:0] o);
        if (needs_p1(o)) return 2'd1;
        if (o == OPC_IMM) return 2'd2;
        return 2'd0;
    endfunction

    assign opc  = bus.opcode;
    assign last = (beat_q == BEAT_LAST);

    // Last-beat decode: where the instruction goes next and which strobes it raises.
    always_comb begin
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        rf_hit    = 1'b0;
        ret       = 1'b0;
        to_trap   = 1'b0;
        nxt_phase = phase_q;
        if (st_q == ST_BOOT) begin
            rd_req = 1'b1;
        end else if (st_q == ST_RUN && last) begin
            case (phase_q)
                2'd0: begin
                    if (needs_p1(opc)) begin
                        nxt_phase = 2'd1;
                    end else if (opc == OPC_IMM || opc == OPC_LUI) begin
                        nxt_phase = 2'd2;
                    end else if (opc == OPC_JAL || opc == OPC_AUIPC || opc == OPC_FENCE) begin
                        ret    = 1'b1;
                        rf_hit = (opc != OPC_FENCE);
                    end else begin
                        to_trap = 1'b1;
                    end
                end
                2'd1: begin
                    if (opc == OPC_STORE) begin
                        // Write first; the retire fetch follows in the same beat once it lands.
                        if (!wdone_q) wr_req = 1'b1;
                        else          ret    = 1'b1;
                    end else begin
                        nxt_phase = 2'd2;
                        rd_req    = (opc == OPC_LOAD) || (opc == OPC_JALR);
                    end
                end
                2'd2: begin
                    if (opc == OPC_BRANCH && bus.branch_taken) begin
                        nxt_phase = 2'd3;
                    end else begin
                        ret    = 1'b1;
                        rf_hit = (opc == OPC_OP) || (opc == OPC_IMM) || (opc == OPC_LUI) ||
                                 (opc == OPC_LOAD) || (opc == OPC_JALR);
                    end
                end
                default: ret = 1'b1;
            endcase
            if (ret && opc != OPC_JALR) rd_req = 1'b1;
        end
    end

    assign go = !bus.stall && (!(rd_req || wr_req) || bus.mem_ready);

    always_comb begin
        st_d    = st_q;
        phase_d = phase_q;
        beat_d  = beat_q;
        start_d = start_q;
        wdone_d = wdone_q;
        case (st_q)
            ST_BOOT: begin
                if (go) begin
                    st_d    = ST_RUN;
                    phase_d = 2'd0;
                    beat_d  = '0;
                    start_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (go) begin
                    if (wr_req) begin
                        wdone_d = 1'b1;
                    end else if (!last) begin
                        beat_d  = beat_q + BW'(1);
                        start_d = 1'b0;
                    end else begin
                        beat_d  = '0;
                        wdone_d = 1'b0;
                        start_d = 1'b0;
                        if (to_trap) begin
                            st_d    = ST_TRAP;
                            phase_d = 2'd0;
                        end else if (ret) begin
                            start_d = 1'b1;
                            phase_d = bus.fwd_taken ? fwd_phase(bus.next_opcode) : 2'd0;
                        end else begin
                            phase_d = nxt_phase;
                        end
                    end
                end
            end
            ST_TRAP: begin
                if (!bus.stall && bus.trap_ack) begin
                    st_d    = ST_BOOT;
                    phase_d = 2'd0;
                    beat_d  = '0;
                    start_d = 1'b1;
                end
            end
            default: begin
                st_d    = ST_BOOT;
                phase_d = 2'd0;
                beat_d  = '0;
                start_d = 1'b1;
                wdone_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_BOOT;
            phase_q <= 2'd0;
            beat_q  <= '0;
            start_q <= 1'b1;
            wdone_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            phase_q <= phase_d;
            beat_q  <= beat_d;
            start_q <= start_d;
            wdone_q <= wdone_d;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.beat       = beat_q;
    assign bus.first_beat = (beat_q == '0);
    assign bus.last_beat  = last;
    assign bus.start      = start_q;
    assign bus.trap       = (st_q == ST_TRAP);
    assign bus.rf_wren    = rf_hit && go;
    assign bus.mem_rden   = rd_req && rst_n;
    assign bus.mem_wren   = wr_req;
    assign bus.retire     = ret && go;

`ifdef PHASE_SEQ_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          instret_q <= 32'd0;
        else if (ret && go)  instret_q <= instret_q + 32'd1;
    end

    assign bus.instret = instret_q;
`else
    assign bus.instret = 32'd0;
`endif
endmodule

// File: tb/tb_phase_seq.sv
// Directed bench for phase_seq: per-cycle vector table plus hand sequences for stall, memory wait, trap and reset.
module tb_phase_seq;
    localparam int XLEN    = 32;
    localparam int DIGIT_W = 8;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;
    localparam logic [4:0] OPC_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYS    = 5'b11100;

    logic clk = 1'b0;
    logic rst_n;

    phase_seq_if #(.XLEN(XLEN), .DIGIT_W(DIGIT_W)) bus ();
    phase_seq #(.XLEN(XLEN), .DIGIT_W(DIGIT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] opc;
        logic       fwd;
        logic [4:0] nop;
        logic       br;
        logic [1:0] ph;
        logic [1:0] b;
        logic       st, rf, rd, wr, ret;
    } row_t;

    row_t tbl[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_ret = 0;
    logic [31:0] instret_hold;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] snap();
        return {bus.phase, bus.beat, bus.start, bus.rf_wren, bus.mem_rden, bus.mem_wren,
                bus.retire, bus.trap, bus.first_beat, bus.last_beat};
    endfunction

    function automatic logic [11:0] expv(input logic [1:0] ph, input logic [1:0] b,
                                         input logic st, rf, rd, wr, ret, tr);
        return {ph, b, st, rf, rd, wr, ret, tr, (b == 2'd0), (b == 2'd3)};
    endfunction

    task automatic add(input logic [4:0] o, input logic fwd, input logic [4:0] nop, input logic br,
                       input logic [1:0] ph, input logic [1:0] b, input logic st, rf, rd, wr, ret);
        row_t r;
        r.opc = o; r.fwd = fwd; r.nop = nop; r.br = br; r.ph = ph; r.b = b;
        r.st = st; r.rf = rf; r.rd = rd; r.wr = wr; r.ret = ret;
        tbl.push_back(r);
    endtask

    // Beats 0..2 of a phase carry no strobes; start only on beat 0 of an instruction's first phase.
    task automatic add_ph(input logic [4:0] o, input logic br, input logic [1:0] ph, input logic st0);
        for (int b = 0; b < 3; b++)
            add(o, 1'b0, OPC_OP, br, ph, 2'(b), (b == 0) && st0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mid(input logic [4:0] o, input logic br, input logic [1:0] ph, input logic rd);
        add(o, 1'b0, OPC_OP, br, ph, 2'd3, 1'b0, 1'b0, rd, 1'b0, 1'b0);
    endtask

    task automatic fin(input logic [4:0] o, input logic fwd, input logic [4:0] nop, input logic br,
                       input logic [1:0] ph, input logic rf, input logic rd);
        add(o, fwd, nop, br, ph, 2'd3, 1'b0, rf, rd, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.opcode = OPC_OP; bus.next_opcode = OPC_OP; bus.branch_taken = 1'b0;
        bus.fwd_taken = 1'b0; bus.stall = 1'b0; bus.mem_ready = 1'b1; bus.trap_ack = 1'b0;

        // OP then OP (fwd off), then OP forwarded into P1
        add_ph(OPC_OP, 0, 0, 1); mid(OPC_OP, 0, 0, 0); add_ph(OPC_OP, 0, 1, 0); mid(OPC_OP, 0, 1, 0);
        add_ph(OPC_OP, 0, 2, 0); fin(OPC_OP, 0, OPC_OP, 0, 2, 1, 1);
        add_ph(OPC_OP, 0, 0, 1); mid(OPC_OP, 0, 0, 0); add_ph(OPC_OP, 0, 1, 0); mid(OPC_OP, 0, 1, 0);
        add_ph(OPC_OP, 0, 2, 0); fin(OPC_OP, 1, OPC_OP, 0, 2, 1, 1);
        add_ph(OPC_OP, 0, 1, 1); mid(OPC_OP, 0, 1, 0);
        add_ph(OPC_OP, 0, 2, 0); fin(OPC_OP, 0, OPC_OP, 0, 2, 1, 1);
        // BRANCH taken (P3), then not taken
        add_ph(OPC_BRANCH, 1, 0, 1); mid(OPC_BRANCH, 1, 0, 0); add_ph(OPC_BRANCH, 1, 1, 0);
        mid(OPC_BRANCH, 1, 1, 0); add_ph(OPC_BRANCH, 1, 2, 0); mid(OPC_BRANCH, 1, 2, 0);
        add_ph(OPC_BRANCH, 1, 3, 0); fin(OPC_BRANCH, 0, OPC_OP, 1, 3, 0, 1);
        add_ph(OPC_BRANCH, 0, 0, 1); mid(OPC_BRANCH, 0, 0, 0); add_ph(OPC_BRANCH, 0, 1, 0);
        mid(OPC_BRANCH, 0, 1, 0); add_ph(OPC_BRANCH, 0, 2, 0); fin(OPC_BRANCH, 0, OPC_OP, 0, 2, 0, 1);
        // JAL forwards IMM into P2; IMM forwards JAL which lands in P0
        add_ph(OPC_JAL, 0, 0, 1); fin(OPC_JAL, 1, OPC_IMM, 0, 0, 1, 1);
        add_ph(OPC_IMM, 0, 2, 1); fin(OPC_IMM, 1, OPC_JAL, 0, 2, 1, 1);
        // JALR: fetch is the P1 read, none at retire
        add_ph(OPC_JALR, 0, 0, 1); mid(OPC_JALR, 0, 0, 0); add_ph(OPC_JALR, 0, 1, 0);
        mid(OPC_JALR, 0, 1, 1); add_ph(OPC_JALR, 0, 2, 0); fin(OPC_JALR, 0, OPC_OP, 0, 2, 1, 0);
        add_ph(OPC_LOAD, 0, 0, 1); mid(OPC_LOAD, 0, 0, 0); add_ph(OPC_LOAD, 0, 1, 0);
        mid(OPC_LOAD, 0, 1, 1); add_ph(OPC_LOAD, 0, 2, 0); fin(OPC_LOAD, 0, OPC_OP, 0, 2, 1, 1);
        // STORE: write beat, then fetch in the same beat
        add_ph(OPC_STORE, 0, 0, 1); mid(OPC_STORE, 0, 0, 0); add_ph(OPC_STORE, 0, 1, 0);
        add(OPC_STORE, 0, OPC_OP, 0, 1, 2'd3, 0, 0, 0, 1, 0); fin(OPC_STORE, 0, OPC_OP, 0, 1, 0, 1);
        add_ph(OPC_AUIPC, 0, 0, 1); fin(OPC_AUIPC, 0, OPC_OP, 0, 0, 1, 1);
        add_ph(OPC_FENCE, 0, 0, 1); fin(OPC_FENCE, 0, OPC_OP, 0, 0, 0, 1);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_phase", 32'(bus.phase), 32'd0);
        chk("rst_beat", 32'(bus.beat), 32'd0);
        chk("rst_start", 32'(bus.start), 32'd1);
        chk("rst_strobes", {28'd0, bus.rf_wren, bus.mem_wren, bus.retire, bus.trap}, 32'd0);
        chk("rst_rden", 32'(bus.mem_rden), 32'd0);
        chk("rst_instret", bus.instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_fetch", 32'(snap()), 32'(expv(0, 0, 1, 0, 1, 0, 0, 0)));
        @(negedge clk);

        foreach (tbl[i]) begin
            bus.opcode = tbl[i].opc; bus.fwd_taken = tbl[i].fwd;
            bus.next_opcode = tbl[i].nop; bus.branch_taken = tbl[i].br;
            #1;
            chk($sformatf("row%0d", i), 32'(snap()),
                32'(expv(tbl[i].ph, tbl[i].b, tbl[i].st, tbl[i].rf, tbl[i].rd, tbl[i].wr, tbl[i].ret, 0)));
            if (tbl[i].ret) exp_ret++;
            @(negedge clk);
        end
        bus.fwd_taken = 1'b0; bus.branch_taken = 1'b0;

        // STORE with memory holding off the write for 3 cycles, then a slow fetch
        bus.opcode = OPC_STORE;
        repeat (7) @(negedge clk);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_wait_wr", 32'(snap()), 32'(expv(1, 3, 0, 0, 0, 1, 0, 0)));
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("st_wr_done", 32'(snap()), 32'(expv(1, 3, 0, 0, 0, 1, 0, 0)));
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("st_fetch_wait", 32'(snap()), 32'(expv(1, 3, 0, 0, 1, 0, 0, 0)));
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        chk("st_fetch_ret", 32'(snap()), 32'(expv(1, 3, 0, 0, 1, 0, 1, 0)));
        exp_ret++;
        @(negedge clk);
        #1;
        chk("st_next", 32'(snap()), 32'(expv(0, 0, 1, 0, 0, 0, 0, 0)));

        // SYS: trap_ack outside TRAP is ignored, then trap and release
        bus.opcode = OPC_SYS; bus.trap_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sys_run", 32'(snap()), 32'(expv(0, 2'(i), (i == 0), 0, 0, 0, 0, 0)));
            @(negedge clk);
        end
        bus.trap_ack = 1'b0;
        #1;
        chk("sys_last", 32'(snap()), 32'(expv(0, 3, 0, 0, 0, 0, 0, 0)));
        instret_hold = bus.instret;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("trap_hold", 32'(snap()), 32'(expv(0, 0, 0, 0, 0, 0, 0, 1)));
            @(negedge clk);
        end
        bus.trap_ack = 1'b1;
        #1;
        chk("trap_ack_cyc", 32'(bus.trap), 32'd1);
        @(negedge clk);
        bus.trap_ack = 1'b0;
        #1;
        chk("trap_boot", 32'(snap()), 32'(expv(0, 0, 1, 0, 1, 0, 0, 0)));
        chk("trap_instret", bus.instret, instret_hold);
        @(negedge clk);

        // LOAD with stalls on the P1 read and on P2 beat 2
        bus.opcode = OPC_LOAD;
        repeat (7) @(negedge clk);
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_rd", 32'(snap()), 32'(expv(1, 3, 0, 0, 1, 0, 0, 0)));
            @(negedge clk);
        end
        bus.stall = 1'b0;
        #1;
        chk("stall_rd_go", 32'(snap()), 32'(expv(1, 3, 0, 0, 1, 0, 0, 0)));
        @(negedge clk);
        repeat (2) @(negedge clk);
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_p2", 32'(snap()), 32'(expv(2, 2, 0, 0, 0, 0, 0, 0)));
            @(negedge clk);
        end
        bus.stall = 1'b0;
        #1;
        chk("stall_p2_go", 32'(snap()), 32'(expv(2, 2, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        #1;
        chk("load_ret", 32'(snap()), 32'(expv(2, 3, 0, 1, 1, 0, 1, 0)));
        exp_ret++;
`ifdef PHASE_SEQ_INSTRET_EN
        chk("instret", bus.instret, 32'(exp_ret - 1));
`else
        chk("instret", bus.instret, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_beat", 32'(bus.beat), 32'd1);

        // Asynchronous reset mid-phase
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(snap()), 32'(expv(0, 0, 1, 0, 0, 0, 0, 0)));
        chk("arst_instret", bus.instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_boot", 32'(snap()), 32'(expv(0, 0, 1, 0, 1, 0, 0, 0)));
        chk("arst_instret2", bus.instret, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
